// File: rtl/datapath_bus_arbiter_pkg.sv
// rtl/datapath_bus_arbiter_pkg.sv - shared constants, state type and width helper for the bus arbiter
package bus_pkg;

    localparam int MODE_FIXED = 0;
    localparam int MODE_RR    = 1;

    typedef enum logic [1:0] {
        IDLE,
        OWNED,
        LOCKED
    } arb_state_e;

    // Keeps index ports at least one bit wide for degenerate source counts.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/datapath_bus_arbiter_rr_picker.sv
// rtl/datapath_bus_arbiter_rr_picker.sv - combinational requester pick, rotating upward or fixed top-down
module rr_picker
    import bus_pkg::*;
#(
    parameter int N_SRC = 22,
    parameter int IDX_W = 5
) (
    input  logic [N_SRC-1:0] req,
    input  logic [IDX_W-1:0] start,
    input  logic             rr_mode,
    output logic [N_SRC-1:0] onehot,
    output logic [IDX_W-1:0] idx,
    output logic             found
);

    int cand;

    // Rotating search walks upward from start; fixed search walks down from the top index.
    always_comb begin
        onehot = '0;
        idx    = '0;
        found  = 1'b0;
        cand   = 0;
        for (int k = 0; k < N_SRC; k++) begin
            if (rr_mode) begin
                cand = int'(start) + k;
                if (cand >= N_SRC) begin
                    cand = cand - N_SRC;
                end
            end else begin
                cand = N_SRC - 1 - k;
            end
            if (!found && req[cand]) begin
                found        = 1'b1;
                idx          = cand[IDX_W-1:0];
                onehot[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/datapath_bus_arbiter.sv
// rtl/datapath_bus_arbiter.sv - registered shared-bus arbiter with lock, round-robin and conflict flag
module datapath_bus_arbiter
    import bus_pkg::*;
#(
    parameter int  WIDTH = 32,
    parameter int  N_SRC = 22,
    parameter int  MODE  = MODE_FIXED,
    localparam int IDX_W = idx_width(N_SRC),
    localparam int CNT_W = $clog2(N_SRC + 1)
) (
    input  logic                   clock,
    input  logic                   clear,
    input  logic [N_SRC*WIDTH-1:0] src_data,
    input  logic [N_SRC-1:0]       src_req,
    input  logic [N_SRC-1:0]       src_lock,
    output logic [WIDTH-1:0]       bus_out,
    output logic                   bus_valid,
    output logic [N_SRC-1:0]       grant,
    output logic [IDX_W-1:0]       grant_idx,
    output logic                   conflict
);

    arb_state_e       state, state_nxt;
    logic [IDX_W-1:0] rr_ptr, rr_ptr_nxt;
    logic [N_SRC-1:0] pick_onehot, grant_nxt;
    logic [IDX_W-1:0] pick_idx, idx_nxt;
    logic             pick_found, valid_nxt;
    logic [CNT_W-1:0] req_count;

    rr_picker #(
        .N_SRC (N_SRC),
        .IDX_W (IDX_W)
    ) u_picker (
        .req     (src_req),
        .start   (rr_ptr),
        .rr_mode (MODE == MODE_RR),
        .onehot  (pick_onehot),
        .idx     (pick_idx),
        .found   (pick_found)
    );

    always_comb begin
        state_nxt  = state;
        grant_nxt  = '0;
        idx_nxt    = '0;
        valid_nxt  = 1'b0;
        rr_ptr_nxt = rr_ptr;
        // A locked owner that still requests keeps the bus and does not advance the pointer.
        if (state == LOCKED && src_req[grant_idx]) begin
            grant_nxt = grant;
            idx_nxt   = grant_idx;
            valid_nxt = 1'b1;
            state_nxt = src_lock[grant_idx] ? LOCKED : OWNED;
        end else if (pick_found) begin
            grant_nxt = pick_onehot;
            idx_nxt   = pick_idx;
            valid_nxt = 1'b1;
            state_nxt = src_lock[pick_idx] ? LOCKED : OWNED;
            if (MODE == MODE_RR) begin
                rr_ptr_nxt = (pick_idx == IDX_W'(N_SRC - 1)) ? '0 : pick_idx + 1'b1;
            end
        end else begin
            state_nxt = IDLE;
        end
    end

    always_comb begin
        req_count = '0;
        for (int k = 0; k < N_SRC; k++) begin
            req_count = req_count + CNT_W'(src_req[k]);
        end
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            bus_out   <= '0;
            bus_valid <= 1'b0;
            grant     <= '0;
            grant_idx <= '0;
            conflict  <= 1'b0;
        end else begin
            state     <= state_nxt;
            rr_ptr    <= rr_ptr_nxt;
            bus_valid <= valid_nxt;
            grant     <= grant_nxt;
            grant_idx <= idx_nxt;
            conflict  <= (req_count >= CNT_W'(2));
            if (valid_nxt) begin
                bus_out <= src_data[int'(idx_nxt)*WIDTH +: WIDTH];
            end
        end
    end

endmodule
